// File: rtl/pnu_clk_div_prog.sv
// rtl/pnu_clk_div_prog.sv - multi-channel programmable clock divider with shadowed divisors
// Divisor writes land in a shadow register and reach the active divisor only at a period boundary.
module pnu_clk_div_prog #(
  parameter int NCH = 4,
  parameter int DIVW = 20,
  parameter int DEF_DIV = 2,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  en,
  input  logic            wr_en,
  input  logic [CHW-1:0]  wr_ch,
  input  logic [DIVW-1:0] wr_div,
  output logic [NCH-1:0]  div_clk,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  pending
);

  logic [NCH-1:0][DIVW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][DIVW-1:0] act_q, act_d;
  logic [NCH-1:0][DIVW-1:0] shd_q, shd_d;
  logic [NCH-1:0][DIVW-1:0] half;
  logic [NCH-1:0]           at_end;
  logic [NCH-1:0]           div_clk_q, div_clk_d;
  logic [NCH-1:0]           tick_q, tick_d;
  logic [NCH-1:0]           pending_q, pending_d;
  logic                     wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_ch} < (CHW+1)'(NCH));

  always_comb begin
    cnt_d     = '0;
    div_clk_d = '0;
    tick_d    = '0;
    act_d     = act_q;
    shd_d     = shd_q;
    pending_d = pending_q;
    half      = '0;
    at_end    = '0;
    for (int i = 0; i < NCH; i++) begin
      half[i]   = act_q[i] >> 1;
      // Divisors 0 and 1 have no multi-cycle period, so every cycle is a boundary.
      at_end[i] = (act_q[i] <= DIVW'(1)) || (cnt_q[i] == act_q[i] - DIVW'(1));
      if (en[i] && (act_q[i] != '0)) begin
        cnt_d[i]     = at_end[i] ? '0 : cnt_q[i] + DIVW'(1);
        div_clk_d[i] = (cnt_q[i] >= half[i]);
        tick_d[i]    = (cnt_q[i] == half[i]);
      end
      // Apply the shadow held before any same-cycle write; that write stays pending.
      if ((!en[i] || at_end[i]) && pending_q[i]) begin
        act_d[i]     = shd_q[i];
        pending_d[i] = 1'b0;
      end
      if (wr_ok && (wr_ch == CHW'(i))) begin
        shd_d[i]     = wr_div;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      act_q     <= {NCH{DIVW'(DEF_DIV)}};
      shd_q     <= {NCH{DIVW'(DEF_DIV)}};
      div_clk_q <= '0;
      tick_q    <= '0;
      pending_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign div_clk = div_clk_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_pnu_clk_div_prog.sv
// tb/tb_pnu_clk_div_prog.sv - self-checking bench for pnu_clk_div_prog
// Table vectors and a cycle model both feed a scoreboard queue checked one edge later.
module tb_pnu_clk_div_prog;

  localparam int NCH = 3;
  localparam int DIVW = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  en = '0;
  logic            wr_en = 1'b0;
  logic [1:0]      wr_ch = '0;
  logic [DIVW-1:0] wr_div = '0;
  logic [NCH-1:0]  div_clk, tick, pending;

  pnu_clk_div_prog #(.NCH(NCH), .DIVW(DIVW), .DEF_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .div_clk(div_clk), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] clk_v;
    logic [2:0] tick_v;
    logic [2:0] pend_v;
    string      name;
  } exp_t;

  typedef struct {
    logic [2:0] en_v;
    logic       wr;
    logic [1:0] ch;
    int         d;
    logic [2:0] e_clk;
    logic [2:0] e_tick;
    logic [2:0] e_pend;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  int m_cnt [NCH];
  int m_a   [NCH];
  int m_s   [NCH];
  bit m_pend[NCH];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endfunction

  task automatic model_step(input logic r, input logic [2:0] e, input logic w,
                            input logic [1:0] ch, input int d, output exp_t x);
    x.clk_v = '0;
    x.tick_v = '0;
    x.pend_v = '0;
    x.name = "";
    for (int i = 0; i < NCH; i++) begin
      bit bnd;
      if (r) begin
        m_cnt[i] = 0; m_a[i] = 2; m_s[i] = 2; m_pend[i] = 0;
      end else begin
        if (e[i] && m_a[i] > 0) begin
          x.clk_v[i]  = (m_cnt[i] >= m_a[i] / 2);
          x.tick_v[i] = (m_cnt[i] == m_a[i] / 2);
          bnd = (m_cnt[i] == m_a[i] - 1);
          m_cnt[i] = bnd ? 0 : m_cnt[i] + 1;
        end else begin
          m_cnt[i] = 0;
          bnd = 1;
        end
        if (bnd && m_pend[i]) begin
          m_a[i] = m_s[i];
          m_pend[i] = 0;
        end
        if (w && ch == i) begin
          m_s[i] = d;
          m_pend[i] = 1;
        end
      end
      x.pend_v[i] = m_pend[i];
    end
  endtask

  task automatic cycle(input logic r, input logic [2:0] e, input logic w, input logic [1:0] ch,
                       input int d, input string nm, input logic tab,
                       input logic [2:0] tc, input logic [2:0] tt, input logic [2:0] tp);
    exp_t x;
    rst = r; en = e; wr_en = w; wr_ch = ch; wr_div = DIVW'(d);
    model_step(r, e, w, ch, d, x);
    if (tab) begin
      x.clk_v = tc; x.tick_v = tt; x.pend_v = tp;
    end
    x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk({x.name, " div_clk"}, 32'(div_clk), 32'(x.clk_v));
    chk({x.name, " tick"}, 32'(tick), 32'(x.tick_v));
    chk({x.name, " pending"}, 32'(pending), 32'(x.pend_v));
  endtask

  task automatic step(input logic [2:0] e, input logic w, input logic [1:0] ch, input int d, input string nm);
    cycle(1'b0, e, w, ch, d, nm, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input logic [2:0] e);
    cycle(1'b1, e, 1'b0, 2'd0, 0, "reset", 1'b1, 3'b000, 3'b000, 3'b000);
    cycle(1'b1, e, 1'b0, 2'd0, 0, "reset", 1'b1, 3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    vec_t vecs[12];
    logic [5:0] pat;
    logic [3:0] pat4;
    logic       all_one, any_one;
    int         rise_at;

    vecs[0]  = '{3'b111, 1'b0, 2'd0, 0, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{3'b111, 1'b0, 2'd0, 0, 3'b111, 3'b111, 3'b000};
    vecs[2]  = '{3'b111, 1'b0, 2'd0, 0, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{3'b111, 1'b0, 2'd0, 0, 3'b111, 3'b111, 3'b000};
    vecs[4]  = '{3'b111, 1'b1, 2'd0, 4, 3'b000, 3'b000, 3'b001};
    vecs[5]  = '{3'b111, 1'b0, 2'd0, 0, 3'b111, 3'b111, 3'b000};
    vecs[6]  = '{3'b111, 1'b0, 2'd0, 0, 3'b000, 3'b000, 3'b000};
    vecs[7]  = '{3'b111, 1'b0, 2'd0, 0, 3'b110, 3'b110, 3'b000};
    vecs[8]  = '{3'b111, 1'b0, 2'd0, 0, 3'b001, 3'b001, 3'b000};
    vecs[9]  = '{3'b111, 1'b0, 2'd0, 0, 3'b111, 3'b110, 3'b000};
    vecs[10] = '{3'b111, 1'b1, 2'd3, 9, 3'b000, 3'b000, 3'b000};
    vecs[11] = '{3'b111, 1'b0, 2'd0, 0, 3'b110, 3'b110, 3'b000};

    // Reset, default divide-by-2, then divide-by-4 on ch0 and an invalid channel write
    do_reset(3'b111);
    for (int i = 0; i < 12; i++)
      cycle(1'b0, vecs[i].en_v, vecs[i].wr, vecs[i].ch, vecs[i].d, $sformatf("vec%0d", i),
            1'b1, vecs[i].e_clk, vecs[i].e_tick, vecs[i].e_pend);

    // Runtime change mid-period: write D=6 at cnt==1
    do_reset(3'b000);
    step(3'b000, 1'b1, 2'd0, 4, "load4");
    step(3'b000, 1'b0, 2'd0, 0, "load4b");
    step(3'b001, 1'b0, 2'd0, 0, "mid_e1");
    step(3'b001, 1'b1, 2'd0, 6, "mid_e2");
    chk("mid pending after write", 32'(pending[0]), 32'd1);
    step(3'b001, 1'b0, 2'd0, 0, "mid_e3");
    chk("mid pending held", 32'(pending[0]), 32'd1);
    step(3'b001, 1'b0, 2'd0, 0, "mid_e4");
    chk("mid pending cleared", 32'(pending[0]), 32'd0);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(3'b001, 1'b0, 2'd0, 0, "mid_p6");
      pat = {pat[4:0], div_clk[0]};
    end
    chk("mid first 6-period", 32'(pat), 32'h07);

    // Write landing on the boundary: old period repeats once
    do_reset(3'b000);
    step(3'b000, 1'b1, 2'd0, 4, "load4");
    step(3'b000, 1'b0, 2'd0, 0, "load4b");
    for (int i = 0; i < 3; i++) step(3'b001, 1'b0, 2'd0, 0, "bnd_run");
    step(3'b001, 1'b1, 2'd0, 6, "bnd_wr");
    chk("bnd pending after write", 32'(pending[0]), 32'd1);
    pat4 = '0;
    for (int i = 0; i < 4; i++) begin
      step(3'b001, 1'b0, 2'd0, 0, "bnd_p4");
      pat4 = {pat4[2:0], div_clk[0]};
    end
    chk("bnd old period", 32'(pat4), 32'h3);
    chk("bnd pending cleared", 32'(pending[0]), 32'd0);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(3'b001, 1'b0, 2'd0, 0, "bnd_p6");
      pat = {pat[4:0], div_clk[0]};
    end
    chk("bnd new 6-period", 32'(pat), 32'h07);

    // Enable edge cases on ch1 (D=5) and ch2 (D=1, D=0)
    do_reset(3'b000);
    step(3'b000, 1'b1, 2'd1, 5, "ld5");
    step(3'b000, 1'b0, 2'd0, 0, "ld5b");
    for (int i = 0; i < 4; i++) step(3'b010, 1'b0, 2'd0, 0, "odd_run");
    chk("odd high before drop", 32'(div_clk[1]), 32'd1);
    step(3'b000, 1'b0, 2'd0, 0, "drop_en");
    chk("drop en low", 32'(div_clk[1]), 32'd0);
    rise_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(3'b010, 1'b0, 2'd0, 0, "reen");
      if (div_clk[1] && rise_at == 0) rise_at = i;
    end
    chk("reenable first rise", 32'(rise_at), 32'd3);
    step(3'b100, 1'b1, 2'd2, 1, "d1_wr");
    step(3'b100, 1'b0, 2'd0, 0, "d1_a");
    step(3'b100, 1'b0, 2'd0, 0, "d1_b");
    all_one = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(3'b100, 1'b0, 2'd0, 0, "d1_run");
      all_one = all_one & div_clk[2] & tick[2];
    end
    chk("d1 constant high", 32'(all_one), 32'd1);
    step(3'b100, 1'b1, 2'd2, 0, "d0_wr");
    step(3'b100, 1'b0, 2'd0, 0, "d0_a");
    any_one = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(3'b100, 1'b0, 2'd0, 0, "d0_run");
      any_one = any_one | div_clk[2] | tick[2];
    end
    chk("d0 parked", 32'(any_one), 32'd0);

    // Isolation: ch0/ch1 run while ch2 and invalid channel are written
    do_reset(3'b000);
    step(3'b000, 1'b1, 2'd0, 4, "iso_l0");
    step(3'b000, 1'b1, 2'd1, 5, "iso_l1");
    step(3'b000, 1'b0, 2'd0, 0, "iso_l2");
    for (int i = 0; i < 40; i++)
      step(3'b011, ($urandom_range(0, 1) == 1), 2'($urandom_range(2, 3)),
           int'($urandom_range(0, 9)), "iso");

    // Random mixed traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0)
        cycle(1'b1, 3'($urandom_range(0, 7)), 1'b1, 2'd0, 7, "rnd_rst", 1'b0, '0, '0, '0);
      else
        step((($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b111),
             ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 9)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
